// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes them to IMEM while holding the CPU. Define LOADER_CHECKSUM_EN for a trailing checksum.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned AW          = 9
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_last_i,
    output logic          rx_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          cpu_hold_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [15:0]   word_count_o
);

    // One extra code so the index can sit at DEPTH_WORDS and flag overflow.
    localparam int unsigned WiW = $clog2(DEPTH_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StCheck, StErr} state_e;
`else
    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StErr} state_e;
`endif

    state_e         state_q, state_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [WiW-1:0] word_idx_q, word_idx_d;
    logic [31:0]    word_buf_q, word_buf_d;
    logic           last_q, last_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           hold_q, hold_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [15:0]    count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
`endif

    logic [31:0]    word_asm;

    always_comb begin
        word_asm = word_buf_q;
        word_asm[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_buf_d = word_buf_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        rx_ready_o = 1'b0;
        imem_we_o  = 1'b0;

        unique case (state_q)
            StIdle, StErr: begin
                if (start_i) begin
                    state_d    = StCollect;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    word_buf_d = '0;
                    last_d     = 1'b0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end

            StCollect: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data_i;
`endif
                    if (byte_idx_q == 2'd3 || rx_last_i) begin
                        if (word_idx_q == WiW'(DEPTH_WORDS)) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StWrite;
                            addr_d  = AW'({word_idx_q, 2'b00});
                            wdata_d = word_asm;
                            last_d  = rx_last_i;
                        end
                    end else begin
                        word_buf_d = word_asm;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            StWrite: begin
                imem_we_o = 1'b1;
                count_d   = count_q + 16'd1;
                if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StIdle;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d    = StCollect;
                    word_idx_d = word_idx_q + 1'b1;
                    byte_idx_d = '0;
                    word_buf_d = '0;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    if (8'(sum_q + rx_data_i) == 8'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StCollect) || (state_q == StWrite);
`ifdef LOADER_CHECKSUM_EN
        busy_o = busy_o || (state_q == StCheck);
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            word_buf_q <= '0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_buf_q <= word_buf_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign word_count_o = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of image loads, write scoreboard, and hand-built
// sequences for reset mid-word, depth overflow and (with LOADER_CHECKSUM_EN) checksum.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       sel_small;

    logic        l_rdy, l_we, l_hold, l_busy, l_done, l_err;
    logic [8:0]  l_addr;
    logic [31:0] l_wdata;
    logic [15:0] l_cnt;
    logic        s_rdy, s_we, s_hold, s_busy, s_done, s_err;
    logic [8:0]  s_addr;
    logic [31:0] s_wdata;
    logic [15:0] s_cnt;

    logic        rdy, we, hold, busy, done, err;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(128), .AW(9)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .rx_valid_i(rx_valid),
        .rx_data_i(rx_data), .rx_last_i(rx_last), .rx_ready_o(l_rdy), .imem_we_o(l_we),
        .imem_addr_o(l_addr), .imem_wdata_o(l_wdata), .cpu_hold_o(l_hold), .busy_o(l_busy),
        .done_o(l_done), .error_o(l_err), .word_count_o(l_cnt)
    );

    imem_loader #(.DEPTH_WORDS(2), .AW(9)) dut_small (
        .clk_i(clk), .reset_i(reset), .start_i(start), .rx_valid_i(rx_valid),
        .rx_data_i(rx_data), .rx_last_i(rx_last), .rx_ready_o(s_rdy), .imem_we_o(s_we),
        .imem_addr_o(s_addr), .imem_wdata_o(s_wdata), .cpu_hold_o(s_hold), .busy_o(s_busy),
        .done_o(s_done), .error_o(s_err), .word_count_o(s_cnt)
    );

    always_comb begin
        if (sel_small) begin
            rdy = s_rdy; we = s_we; hold = s_hold; busy = s_busy; done = s_done;
            err = s_err; addr = s_addr; wdata = s_wdata; cnt = s_cnt;
        end else begin
            rdy = l_rdy; we = l_we; hold = l_hold; busy = l_busy; done = l_done;
            err = l_err; addr = l_addr; wdata = l_wdata; cnt = l_cnt;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: expected writes queued at stimulus time, popped as writes appear.
    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always @(negedge clk) begin
        if (!reset && we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h, want no write", addr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(addr), 32'(e.addr));
                check("wr_data", wdata, e.data);
            end
        end
    end

    typedef struct {
        logic [63:0] bytes;
        logic [63:0] exp;
        int          n;
        int          cnt;
        bit          gap;
        bit          mid_start;
    } vec_t;
    vec_t vecs[5];

    task automatic push_wr(input int word, input logic [31:0] data);
        wr_t e;
        e.addr = 9'(4 * word);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic gap,
                             input logic pulse, input logic exp_we);
        int n;
        @(negedge clk);
        if (gap) begin
            rx_valid = 1'b0;
            start    = pulse;
            @(negedge clk);
            start    = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        rx_last  = last;
        n = 0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got ready 0 for 40 cycles, want 1");
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        check("we_latency", 32'(we), 32'(exp_we));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, 32'(rdy), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_hold"}, 32'(hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cnt"}, 32'(cnt), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] b;
        logic [7:0] sum;
        logic       fin;
        sum = 8'd0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_after_start", 32'(hold), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            b   = v.bytes[8*k +: 8];
            sum = sum + b;
            fin = (k % 4 == 3) || (k == v.n - 1);
            if (fin) push_wr(k / 4, v.exp[32*(k/4) +: 32]);
            send_byte(b, k == v.n - 1, v.gap, v.mid_start && k == 5, fin);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'd0 - sum, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        wait_idle();
        check("done", 32'(done), 32'd1);
        check("err", 32'(err), 32'd0);
        check("hold_released", 32'(hold), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("word_count", 32'(cnt), 32'(v.cnt));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within 500000 time units, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h0010_0093_0000_0013, {32'h0010_0093, 32'h0000_0013}, 8, 2, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_2211_DDCC_BBAA, {32'h0000_2211, 32'hDDCC_BBAA}, 6, 2, 1'b0, 1'b0};
        vecs[2] = '{64'h0010_0093_0000_0013, {32'h0010_0093, 32'h0000_0013}, 8, 2, 1'b1, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_005A, {32'h0000_0000, 32'h0000_005A}, 1, 1, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_1234_5678, {32'h0000_0000, 32'h1234_5678}, 4, 1, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
        sel_small = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_big");
        sel_small = 1'b1;
        #1;
        check_reset_vals("rst_small");
        sel_small = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle_big");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset lands asynchronously after two bytes of word 0.
        pulse_start();
        send_byte(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("post_rst");
        run_vec(vecs[0]);

        // Depth-2 instance: the third word overflows and must not be written.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sel_small = 1'b1;
        pulse_start();
        push_wr(0, 32'h0403_0201);
        push_wr(1, 32'h0807_0605);
        for (int k = 0; k < 12; k++) begin
            send_byte(8'(k + 1), k == 11, 1'b0, 1'b0, k == 3 || k == 7);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        @(negedge clk);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_hold", 32'(hold), 32'd1);
        check("ovf_cnt", 32'(cnt), 32'd2);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_rdy", 32'(rdy), 32'd0);
        check("ovf_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("err_held", 32'(err), 32'd1);
        pulse_start();
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_hold", 32'(hold), 32'd1);
        check("restart_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sel_small = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            pulse_start();
            push_wr(0, 32'h0403_0201);
            for (int k = 0; k < 4; k++) send_byte(8'(k + 1), k == 3, 1'b0, 1'b0, k == 3);
            send_byte((t == 0) ? 8'hF6 : 8'hF5, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            @(negedge clk);
            check("csum_done", 32'(done), (t == 0) ? 32'd1 : 32'd0);
            check("csum_err", 32'(err), (t == 0) ? 32'd0 : 32'd1);
            check("csum_hold", 32'(hold), (t == 0) ? 32'd0 : 32'd1);
            check("csum_pending", 32'(exp_q.size()), 32'd0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
